// File: rtl/led_pwm_controller_pkg.sv
// Shared definitions for the LED PWM controller: channel mode codes,
// register select codes and write-bus field widths.
package led_pwm_controller_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    localparam logic SEL_MODE  = 1'b0;
    localparam logic SEL_DUTY  = 1'b1;

    localparam int CH_BITS   = 4;
    localparam int ADDR_BITS = CH_BITS + 1;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode register, shadow/active duty pair with glitch-free
// update on the PWM wrap, optional gamma stage and the output compare.
// Build option: define LED_GAMMA_EN to square the duty on its way from
// shadow to active; without it no multiplier is built.
module led_pwm_channel
    import led_pwm_controller_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_BITS-1:0]  pwm_cnt,
    input  logic                 wrap,
    input  logic                 blink_phase,
    input  logic                 mode_we,
    input  logic                 duty_we,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 led_next
);

    mode_e               mode;
    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] load;
    logic                lit;

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] shadow_wide;
    logic [2*PWM_BITS-1:0] shadow_sq;

    // Gamma: square the shadow duty and keep the upper half of the product.
    assign shadow_wide = {{PWM_BITS{1'b0}}, shadow};
    assign shadow_sq   = shadow_wide * shadow_wide;
    assign load        = shadow_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign load = shadow;
`endif

    // Register writes land immediately; active duty only changes on wrap so a
    // period is never cut short or stretched by a mid-period DUTY write.
    always_ff @(posedge clk) begin
        // NOTE: every register here is a handful of flops, so all of them take
        // the reset; nothing is memory-like that would justify leaving it unreset.
        if (rst) begin
            mode   <= MODE_OFF;
            shadow <= '0;
            active <= '0;
        end else begin
            // NOTE: non-blocking assignments make a write and a wrap in the same
            // cycle load active from the old shadow while shadow takes the new value.
            if (mode_we) mode   <= mode_e'(wr_data[1:0]);
            if (duty_we) shadow <= wr_data[PWM_BITS-1:0];
            if (wrap)    active <= load;
        end
    end

    // Next LED value from the mode and an unsigned PWM compare.
    always_comb begin
        // NOTE: led_next gets a default before the case so no latch is inferred.
        led_next = 1'b0;
        lit      = (pwm_cnt < active);
        case (mode)
            MODE_OFF:   led_next = 1'b0;
            MODE_ON:    led_next = 1'b1;
            MODE_PWM:   led_next = lit;
            MODE_BLINK: led_next = lit & blink_phase;
            default:    led_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pwm_controller.sv
// Multi-channel LED driver top: prescaler, PWM and blink counters, write
// address decode, registered pwm_wrap and registered LED outputs.
// Build option: LED_GAMMA_EN (see led_pwm_channel) enables duty gamma.
module led_pwm_controller
    import led_pwm_controller_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 64,
    parameter int BLINK_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 en_sig,
    output logic                 pwm_wrap,
    output logic [NUM_LEDS-1:0]  leds
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRESC_W-1:0]    presc;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  step;
    logic                  wrap;
    logic [CH_BITS-1:0]    wr_ch;
    logic                  wr_sel;
    logic [NUM_LEDS-1:0]   led_next;

    assign step   = (presc == PRESC_W'(PRESCALE - 1));
    assign wrap   = step & (&pwm_cnt);
    assign wr_ch  = wr_addr[ADDR_BITS-1:1];
    assign wr_sel = wr_addr[0];
    assign en_sig = wr_en;

    // Timebase: prescaler steps pwm_cnt, each full PWM period steps blink_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            presc <= step ? '0 : presc + 1'b1;
            if (step) pwm_cnt   <= pwm_cnt + 1'b1;
            if (wrap) blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Channels; addresses naming a channel beyond NUM_LEDS match no instance
    // and are therefore dropped without side effects.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic hit;
        assign hit = wr_en & (wr_ch == CH_BITS'(i));

        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pwm_cnt     (pwm_cnt),
            .wrap        (wrap),
            .blink_phase (blink_cnt[BLINK_BITS-1]),
            .mode_we     (hit & (wr_sel == SEL_MODE)),
            .duty_we     (hit & (wr_sel == SEL_DUTY)),
            .wr_data     (wr_data),
            .led_next    (led_next[i])
        );
    end

    // Output register: pins see clean flop outputs, one cycle after the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds     <= '0;
            pwm_wrap <= 1'b0;
        end else begin
            leds     <= led_next;
            pwm_wrap <= wrap;
        end
    end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Self-checking bench for led_pwm_controller (PRESCALE=1, PWM_BITS=8,
// NUM_LEDS=4). Expected per-period high counts are queued when the
// stimulus is driven and compared when a period has been observed.
// Build option: LED_GAMMA_EN changes the expected duty of the last test.
module tb_led_pwm_controller;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       en_sig;
    logic       pwm_wrap;
    logic [3:0] leds;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        int    exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    led_pwm_controller #(
        .NUM_LEDS   (4),
        .PWM_BITS   (8),
        .PRESCALE   (1),
        .BLINK_BITS (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .en_sig   (en_sig),
        .pwm_wrap (pwm_wrap),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_compare(input int got);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check("sb_underflow", sb_q.size(), 1);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, got, it.exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drive(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic wait_wrap();
        int n = 0;
        while (!pwm_wrap && n < 600) begin
            step_clk();
            n++;
        end
        check("wait_wrap_found", pwm_wrap, 1);
    endtask

    // Called right after pwm_wrap is seen: counts lit cycles of one channel
    // over the next full period. Optionally drives a write into the wrap cycle.
    task automatic measure(input int ch, input bit late, input logic [4:0] la,
                           input logic [7:0] ld, output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step_clk();
            cnt += int'(leds[ch]);
            if (late && i == 254) drive(la, ld);
        end
        check("period_end_wrap", pwm_wrap, 1);
    endtask

    initial begin
        int cnt;
        int n;

        // Reset held 3 cycles with writes attempted (ch2 MODE=ON)
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'b00100;
        wr_data = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_leds", leds, 0);
        check("reset_pwm_wrap", pwm_wrap, 0);
        check("en_sig_high", en_sig, 1);
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check("en_sig_low", en_sig, 0);
        n = 0;
        while (!pwm_wrap && n < 1000) begin
            step_clk();
            n++;
        end
        check("first_wrap_latency", n, 256);
        check("leds_after_reset_write", leds, 0);

        // MODE latency: ch2 ON then OFF
        drive(5'b00100, 8'h01);
        step_clk();
        check("mode_on_edge_n", leds, 0);
        step_clk();
        check("mode_on_edge_n1", leds, 4'b0100);
        drive(5'b00100, 8'h00);
        step_clk();
        check("mode_off_edge_m", leds, 4'b0100);
        step_clk();
        check("mode_off_edge_m1", leds, 0);

        // ch0 PWM with DUTY 0x40, then DUTY 0x00
        drive(5'b00000, 8'h02);
        step_clk();
        drive(5'b00001, 8'h40);
        step_clk();
        sb_push("duty_40", 64);
        wait_wrap();
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        drive(5'b00001, 8'h00);
        sb_push("duty_40_persists", 64);
        sb_push("duty_00", 0);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);

        // DUTY write coinciding with wrap
        drive(5'b00001, 8'h20);
        sb_push("duty_pending_old0", 0);
        sb_push("duty_20", 32);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        sb_push("wrap_write_old_persists", 32);
        sb_push("wrap_write_new", 192);
        measure(0, 1'b1, 5'b00001, 8'hC0, cnt);
        sb_compare(cnt);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        drive(5'b00000, 8'h00);
        step_clk();
        step_clk();
        check("ch0_off", leds, 0);

        // Writes to channels beyond NUM_LEDS are ignored
        drive(5'b01110, 8'h01);
        step_clk();
        drive(5'b01111, 8'hFF);
        step_clk();
        drive(5'b11110, 8'h01);
        step_clk();
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check("ignored_channel_write", leds, 0);
        end

        // Reset mid-period
        drive(5'b00100, 8'h01);
        step_clk();
        step_clk();
        check("pre_reset_on", leds, 4'b0100);
        repeat (37) step_clk();
        rst = 1'b1;
        step_clk();
        check("mid_reset_leds", leds, 0);
        check("mid_reset_wrap", pwm_wrap, 0);
        rst = 1'b0;
        step_clk();
        step_clk();
        check("mode_cleared_by_reset", leds, 0);

        // ch1 BLINK with max duty: 32 dark periods, 32 at 255/256, then dark
        drive(5'b00010, 8'h03);
        step_clk();
        drive(5'b00011, 8'hFF);
        step_clk();
        for (int k = 1; k <= 64; k++)
            sb_push($sformatf("blink_p%0d", k), (k >= 32 && k < 64) ? 255 : 0);
        wait_wrap();
        for (int k = 1; k <= 64; k++) begin
            measure(1, 1'b0, 5'b0, 8'h0, cnt);
            sb_compare(cnt);
        end

        // Duty 0x80 / 0xFF, gamma-dependent
        drive(5'b00010, 8'h00);
        step_clk();
        drive(5'b00000, 8'h02);
        step_clk();
        drive(5'b00001, 8'h80);
        step_clk();
`ifdef LED_GAMMA_EN
        sb_push("duty_80", 64);
`else
        sb_push("duty_80", 128);
`endif
        wait_wrap();
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        drive(5'b00001, 8'hFF);
`ifdef LED_GAMMA_EN
        sb_push("duty_80_persists", 64);
        sb_push("duty_ff", 254);
`else
        sb_push("duty_80_persists", 128);
        sb_push("duty_ff", 255);
`endif
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);
        measure(0, 1'b0, 5'b0, 8'h0, cnt);
        sb_compare(cnt);

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
